// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: core MEM stage vs. external loader/debug port.
// Ext wins when core is idle or after STARVE_MAX consecutive core wins while ext waits.
module dmem_arbiter #(
  parameter int A_W        = 8,
  parameter int D_W        = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           core_cs,
  input  logic           core_we,
  input  logic [2:0]     core_funct3,
  input  logic [A_W-1:0] core_addr,
  input  logic [D_W-1:0] core_wdata,
  output logic [D_W-1:0] core_rdata,
  output logic           core_stall,
  input  logic           ext_req,
  input  logic           ext_we,
  input  logic [A_W-1:0] ext_addr,
  input  logic [D_W-1:0] ext_wdata,
  output logic           ext_ack,
  output logic [D_W-1:0] ext_rdata,
  output logic           mem_cs,
  output logic           mem_we,
  output logic [2:0]     mem_funct3,
  output logic [A_W-1:0] mem_addr,
  output logic [D_W-1:0] mem_wdata,
  input  logic [D_W-1:0] mem_rdata,
  output logic           dbg_state,
  output logic [3:0]     dbg_starve_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e         state_q, state_d;
  logic [3:0]     starve_cnt_q, starve_cnt_d;
  logic           ext_ack_q, ext_ack_d;
  logic [D_W-1:0] ext_rdata_q, ext_rdata_d;
  logic           ext_gnt, core_gnt;

  // Handshake: ext_req is a valid held with stable fields until the transfer
  // completes; ext_ack is a one-cycle completion pulse one cycle after the grant.
  // Grants are gated by rst_n so every combinational output is inactive in reset.
  always_comb begin
    ext_gnt  = rst_n && (state_q == ST_IDLE) && ext_req &&
               (!core_cs || (starve_cnt_q == STARVE_LIM));
    core_gnt = rst_n && core_cs && !ext_gnt;

    state_d      = ext_gnt ? ST_ACK : ST_IDLE;
    starve_cnt_d = starve_cnt_q;
    if (ext_gnt) begin
      starve_cnt_d = 4'd0;
    end else if ((state_q == ST_IDLE) && core_gnt && ext_req &&
                 (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    ext_ack_d   = ext_gnt;
    ext_rdata_d = (ext_gnt && !ext_we) ? mem_rdata : ext_rdata_q;

    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (ext_gnt) begin
      mem_cs     = 1'b1;
      mem_we     = ext_we;
      mem_funct3 = 3'b010;
      mem_addr   = ext_addr;
      mem_wdata  = ext_wdata;
    end else if (core_gnt) begin
      mem_cs     = 1'b1;
      mem_we     = core_we;
      mem_funct3 = core_funct3;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
    end

    core_rdata = core_gnt ? mem_rdata : '0;
    core_stall = core_cs && ext_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
      ext_ack_q    <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ext_ack_q    <= ext_ack_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign ext_ack        = ext_ack_q;
  assign ext_rdata      = ext_rdata_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory of the RV32I pipeline. It shares the memory between the core's MEM stage and an external loader/debug port (ext). It sequences ext transactions with a req/ack handshake and stalls the core's MEM stage when ext takes the port. A starvation counter guarantees ext eventual access under continuous core traffic. It sits between EX_ME/ME_WB and DMEM; HAZARD_UNIT ORs `core_stall` into its freeze logic.

## Interface
- `A_W`, 8, memory byte-address width
- `D_W`, 32, data width
- `STARVE_MAX`, 4, consecutive core grants allowed while ext is pending before ext is forced in; legal range 0..15
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `core_cs` in 1: MEM-stage memory access request (level, per cycle)
- `core_we` in 1: 1 = store, 0 = load
- `core_funct3` in 3: access size/sign, passed through to memory
- `core_addr` in A_W: core byte address
- `core_wdata` in D_W: core store data
- `core_rdata` out D_W: load data to the MEM stage
- `core_stall` out 1: holds the MEM stage and everything upstream of it this cycle
- `ext_req` in 1: ext request; held with stable fields until `ext_ack`
- `ext_we` in 1: ext store = 1, load = 0
- `ext_addr` in A_W: ext byte address (word-aligned)
- `ext_wdata` in D_W: ext store data
- `ext_ack` out 1: one-cycle completion pulse
- `ext_rdata` out D_W: registered ext load data, valid while `ext_ack` = 1
- `mem_cs`, `mem_we`, `mem_funct3`, `mem_addr`, `mem_wdata` out 1/1/3/A_W/D_W: DMEM port
- `mem_rdata` in D_W: DMEM combinational read data

## Operation
- State machine has two states. IDLE accepts either requester. ACK is the single cycle in which `ext_ack` = 1.
- Starvation counter `starve_cnt` is 4 bits and saturates at STARVE_MAX.
- Grant decision in IDLE (combinational from state, counter and inputs):
  - If `ext_req` && (!`core_cs` || `starve_cnt` == STARVE_MAX), grant ext. `starve_cnt` goes to 0, next state is ACK.
  - Otherwise, if `core_cs`, grant core. If `ext_req` is also high, `starve_cnt` increments (saturating).
  - Otherwise there is no grant and the counter holds.
- In ACK: grant core if `core_cs`. `ext_req` is ignored and the counter holds. Next state is IDLE.
- Ext grant drives the memory as follows: `mem_cs`=1, `mem_we`=`ext_we`, `mem_funct3`=3'b010 (full word), `mem_addr`=`ext_addr`, `mem_wdata`=`ext_wdata`.
- `ext_rdata` captures `mem_rdata` on the grant-cycle edge for loads. For stores it is unchanged.
- Core grant drives the memory directly from the `core_*` inputs. `core_rdata` = `mem_rdata`.
- `core_stall` = `core_cs` && ext granted this cycle. The stalled core access repeats the next cycle with unchanged fields.
- No grant drives all `mem_*` outputs to 0. `core_rdata` = 0 whenever core is not granted.
- STARVE_MAX = 0 means ext always wins when requesting, but it still obeys the one-cycle ACK gap.
- Ext throughput is at most one transaction per 2 cycles. Core throughput is 1 per cycle except when stalled.

## Timing
- Core access has zero added latency. Address and read data are in the same cycle; the store commits on the edge of the grant cycle.
- Ext access: grant in cycle N, `ext_ack` high in cycle N+1 only, `ext_rdata` valid in N+1 and held until the next ext load.
- Requester rules:
  - Ext may change its fields or drop `ext_req` in the cycle after it observes `ext_ack`.
  - If `ext_req` is still high after the ACK cycle, it is a new transaction. The earliest next grant is N+2.
- Reset values: state IDLE, `starve_cnt`=0, `ext_ack`=0, `ext_rdata`=0.
- While `rst_n`=0, combinational outputs are forced inactive: `mem_cs`=0, `mem_we`=0, `core_stall`=0, `core_rdata`=0.
- Reset asserted during an ext grant cycle: no ack is issued and no partial state remains. Ext must reissue the request after reset.
- `rst_n` deassertion takes effect asynchronously to state. The first grant can occur in the first cycle with `rst_n`=1.

## Test plan
- Ext store then load with core idle: ext store to `ext_addr`=0x10 with `ext_wdata`=0xDEADBEEF. The bench must see `mem_cs`=`mem_we`=1 in cycle N and `ext_ack` in N+1. A following ext load of 0x10 must return `ext_rdata`=0xDEADBEEF with its ack.
- Core load only: `core_cs`=1, `core_addr`=0x10, DMEM holding 0x12345678. Required: `core_rdata`=0x12345678 in the same cycle and `core_stall`=0 every cycle.
- Contention, STARVE_MAX=4: `core_cs` held high and `ext_req` raised at cycle 0.
  - Core is granted in cycles 0-3.
  - Ext is granted in cycle 4 with `core_stall`=1.
  - `ext_ack` fires in cycle 5 and core is granted in cycle 5.
  - `starve_cnt`=0 after cycle 4.
- STARVE_MAX=0 with simultaneous `core_cs` and `ext_req` at cycle 0: ext is granted in cycle 0 with `core_stall`=1, and core is granted in cycle 1.
- Back-to-back ext with `ext_req` held high for 6 cycles and core idle: grants in cycles 0, 2, 4 and acks in cycles 1, 3, 5. `mem_cs`=0 in the ACK cycles.
- Reset mid-operation: `rst_n` pulled low during an ext grant cycle. Required: `ext_ack` never pulses, all `mem_*` outputs are 0 immediately, and after release `starve_cnt`=0 and state is IDLE.
